// File: rtl/mult_16bits_arbiter.sv
// Round-robin front end for one shared combinational multiplier: grants one
// requester per cycle, registers its operands, then captures the tagged product.
module mult_16bits_arbiter #(
   parameter int N    = 16,
   parameter int REQS = 4,
   parameter int IDW  = $clog2(REQS)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [REQS-1:0]          req_valid,
   input  logic [REQS-1:0][N-1:0]   req_a,
   input  logic [REQS-1:0][N-1:0]   req_b,
   output logic [REQS-1:0]          req_ready,
   output logic [N-1:0]             mul_a,
   output logic [N-1:0]             mul_b,
   input  logic [2*N-1:0]           mul_out,
   output logic                     rsp_valid,
   output logic [IDW-1:0]           rsp_id,
   output logic [2*N-1:0]           rsp_data,
   input  logic                     rsp_ready,
   output logic [31:0]              op_count
);

   logic            s1Valid_q, s1Valid_d;
   logic [IDW-1:0]  s1Id_q, s1Id_d;
   logic [N-1:0]    mulA_q, mulA_d;
   logic [N-1:0]    mulB_q, mulB_d;
   logic            rspValid_q, rspValid_d;
   logic [IDW-1:0]  rspId_q, rspId_d;
   logic [2*N-1:0]  rspData_q, rspData_d;
   logic [31:0]     opCount_q, opCount_d;
   logic [IDW-1:0]  lastGrant_q, lastGrant_d;

   logic            s2Load;
   logic            s1Free;
   logic            grantFound;
   logic [IDW-1:0]  grantIdx;
   logic [REQS-1:0] grantOh;

   assign s2Load = s1Valid_q & (~rspValid_q | rsp_ready);
   assign s1Free = ~s1Valid_q | s2Load;

   // Search starts one past the last winner so every waiting requester is
   // reached within REQS-1 grants to others.
   always_comb begin
      int             idx;
      logic [IDW-1:0] idxC;
      grantFound = 1'b0;
      grantIdx   = '0;
      grantOh    = '0;
      idx        = 0;
      idxC       = '0;
      if (!reset && s1Free) begin
         for (int off = 1; off <= REQS; off++) begin
            idx = int'(lastGrant_q) + off;
            if (idx >= REQS) idx = idx - REQS;
            idxC = IDW'(idx);
            if (!grantFound && req_valid[idxC]) begin
               grantFound = 1'b1;
               grantIdx   = idxC;
            end
         end
      end
      if (grantFound) grantOh[grantIdx] = 1'b1;
   end

   always_comb begin
      s1Valid_d   = s1Valid_q;
      s1Id_d      = s1Id_q;
      mulA_d      = mulA_q;
      mulB_d      = mulB_q;
      rspValid_d  = rspValid_q;
      rspId_d     = rspId_q;
      rspData_d   = rspData_q;
      opCount_d   = opCount_q;
      lastGrant_d = lastGrant_q;

      if (s1Free) s1Valid_d = grantFound;
      // Operands are left untouched when S1 drains without a new grant.
      if (grantFound) begin
         s1Id_d      = grantIdx;
         mulA_d      = req_a[grantIdx];
         mulB_d      = req_b[grantIdx];
         lastGrant_d = grantIdx;
      end

      if (s2Load) begin
         rspValid_d = 1'b1;
         rspId_d    = s1Id_q;
         rspData_d  = mul_out;
      end else if (rsp_ready) begin
         rspValid_d = 1'b0;
      end

      if (rspValid_q && rsp_ready) opCount_d = opCount_q + 32'd1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         s1Valid_q   <= 1'b0;
         s1Id_q      <= '0;
         mulA_q      <= '0;
         mulB_q      <= '0;
         rspValid_q  <= 1'b0;
         rspId_q     <= '0;
         rspData_q   <= '0;
         opCount_q   <= '0;
         lastGrant_q <= IDW'(REQS - 1);
      end else begin
         s1Valid_q   <= s1Valid_d;
         s1Id_q      <= s1Id_d;
         mulA_q      <= mulA_d;
         mulB_q      <= mulB_d;
         rspValid_q  <= rspValid_d;
         rspId_q     <= rspId_d;
         rspData_q   <= rspData_d;
         opCount_q   <= opCount_d;
         lastGrant_q <= lastGrant_d;
      end
   end

   assign req_ready = grantOh;
   assign mul_a     = mulA_q;
   assign mul_b     = mulB_q;
   assign rsp_valid = rspValid_q;
   assign rsp_id    = rspId_q;
   assign rsp_data  = rspData_q;
   assign op_count  = opCount_q;

endmodule

// File: tb/tb_mult_16bits_arbiter.sv
// Directed checks of grant order, latency, backpressure, extremes and reset,
// followed by a short randomized scoreboard run against the shared multiplier.
module tb_mult_16bits_arbiter;

   localparam int N    = 16;
   localparam int REQS = 4;
   localparam int IDW  = 2;

   logic                    clock = 1'b0;
   logic                    reset;
   logic [REQS-1:0]         reqValid;
   logic [REQS-1:0][N-1:0]  reqA;
   logic [REQS-1:0][N-1:0]  reqB;
   logic [REQS-1:0]         reqReady;
   logic [N-1:0]            mulA;
   logic [N-1:0]            mulB;
   logic [2*N-1:0]          mulOut;
   logic                    rspValid;
   logic [IDW-1:0]          rspId;
   logic [2*N-1:0]          rspData;
   logic                    rspReady;
   logic [31:0]             opCount;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [31:0]    prod;
   } expT;

   expT expQ[$];

   mult_16bits_arbiter #(.N(N), .REQS(REQS), .IDW(IDW)) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (reqValid),
      .req_a     (reqA),
      .req_b     (reqB),
      .req_ready (reqReady),
      .mul_a     (mulA),
      .mul_b     (mulB),
      .mul_out   (mulOut),
      .rsp_valid (rspValid),
      .rsp_id    (rspId),
      .rsp_data  (rspData),
      .rsp_ready (rspReady),
      .op_count  (opCount)
   );

   // The shared multiplier lives outside the block, so the bench plays its part.
   assign mulOut = {16'b0, mulA} * {16'b0, mulB};

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic stepClock();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic [REQS-1:0] valid, input logic ready);
      reqValid = valid;
      rspReady = ready;
      #1;
   endtask

   initial begin
      logic [REQS-1:0] pending;
      int              waitCnt [REQS];
      int              expOps;
      int              g;
      expT             e;
      logic [15:0]     extA [3];
      logic [15:0]     extB [3];
      logic [31:0]     extP [3];

      reset = 1'b1;
      reqA = '0;
      reqB = '0;
      applyStimulus(4'b1111, 1'b1);
      checkOutput("ready_in_reset", reqReady, 0);
      stepClock();
      stepClock();
      checkOutput("reset_rsp_valid", rspValid, 0);
      checkOutput("reset_mul_a", mulA, 0);
      checkOutput("reset_op_count", opCount, 0);
      checkOutput("reset_rsp_data", rspData, 0);

      // All four requesters valid continuously, A=i+1, B=10
      reset = 1'b0;
      for (int i = 0; i < REQS; i++) begin
         reqA[i] = 16'(i + 1);
         reqB[i] = 16'd10;
      end
      for (int c = 0; c < 6; c++) begin
         applyStimulus(4'b1111, 1'b1);
         checkOutput($sformatf("rr_grant%0d", c), reqReady, 64'(1 << (c % 4)));
         stepClock();
         if (c >= 1) begin
            checkOutput($sformatf("rr_rsp_valid%0d", c), rspValid, 1);
            checkOutput($sformatf("rr_rsp_id%0d", c), rspId, 64'((c - 1) % 4));
            checkOutput($sformatf("rr_rsp_data%0d", c), rspData, 64'(((c - 1) % 4 + 1) * 10));
         end
      end
      applyStimulus(4'b0000, 1'b1);
      stepClock();
      checkOutput("rr_last_id", rspId, 1);
      checkOutput("rr_last_data", rspData, 20);
      stepClock();
      checkOutput("rr_drained", rspValid, 0);
      checkOutput("rr_op_count", opCount, 6);

      // Single request with 2-cycle latency
      reqA[0] = 16'd40119;
      reqB[0] = 16'd63669;
      applyStimulus(4'b0001, 1'b1);
      checkOutput("single_grant", reqReady, 4'b0001);
      stepClock();
      applyStimulus(4'b0000, 1'b1);
      checkOutput("single_mul_a", mulA, 40119);
      checkOutput("single_mul_b", mulB, 63669);
      checkOutput("single_not_yet", rspValid, 0);
      stepClock();
      checkOutput("single_rsp_valid", rspValid, 1);
      checkOutput("single_rsp_id", rspId, 0);
      checkOutput("single_rsp_data", rspData, 64'd2554336611);
      stepClock();
      checkOutput("single_op_count", opCount, 7);
      checkOutput("single_done", rspValid, 0);

      // Backpressure on a stream from requester 2
      reqA[2] = 16'd7;
      reqB[2] = 16'd3;
      applyStimulus(4'b0100, 1'b0);
      checkOutput("bp_grant0", reqReady, 4'b0100);
      stepClock();
      reqA[2] = 16'd8;
      applyStimulus(4'b0100, 1'b0);
      checkOutput("bp_grant1", reqReady, 4'b0100);
      stepClock();
      reqA[2] = 16'd9;
      for (int c = 0; c < 3; c++) begin
         applyStimulus(4'b0100, 1'b0);
         checkOutput($sformatf("bp_stall_ready%0d", c), reqReady, 0);
         checkOutput($sformatf("bp_hold_data%0d", c), rspData, 21);
         checkOutput($sformatf("bp_hold_id%0d", c), rspId, 2);
         stepClock();
      end
      applyStimulus(4'b0100, 1'b1);
      checkOutput("bp_reassert", reqReady, 4'b0100);
      stepClock();
      applyStimulus(4'b0000, 1'b1);
      checkOutput("bp_drain1", rspData, 24);
      stepClock();
      checkOutput("bp_drain2", rspData, 27);
      checkOutput("bp_drain2_valid", rspValid, 1);
      stepClock();
      checkOutput("bp_empty", rspValid, 0);
      checkOutput("bp_op_count", opCount, 10);

      // Operand extremes through requester 1
      extA = '{16'hFFFF, 16'h0000, 16'h0001};
      extB = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
      extP = '{32'hFFFE0001, 32'h0, 32'd65535};
      for (int k = 0; k < 3; k++) begin
         reqA[1] = extA[k];
         reqB[1] = extB[k];
         applyStimulus(4'b0010, 1'b1);
         stepClock();
         applyStimulus(4'b0000, 1'b1);
         stepClock();
         checkOutput($sformatf("ext_data%0d", k), rspData, 64'(extP[k]));
         stepClock();
      end

      // Reset with both stages full
      reqA[0] = 16'd5;
      reqB[0] = 16'd5;
      applyStimulus(4'b0001, 1'b0);
      stepClock();
      stepClock();
      checkOutput("full_before_reset", rspValid, 1);
      reset = 1'b1;
      applyStimulus(4'b1001, 1'b0);
      checkOutput("mid_reset_ready", reqReady, 0);
      stepClock();
      checkOutput("mid_reset_rsp_valid", rspValid, 0);
      checkOutput("mid_reset_op_count", opCount, 0);
      checkOutput("mid_reset_ready2", reqReady, 0);
      reset = 1'b0;
      reqA[3] = 16'd2;
      reqB[3] = 16'd2;
      applyStimulus(4'b1001, 1'b1);
      checkOutput("post_reset_grant", reqReady, 4'b0001);
      stepClock();
      applyStimulus(4'b0000, 1'b1);
      checkOutput("no_ghost_rsp", rspValid, 0);
      stepClock();
      checkOutput("post_reset_rsp_id", rspId, 0);
      checkOutput("post_reset_rsp_data", rspData, 25);
      stepClock();
      expOps = 1;
      checkOutput("post_reset_op_count", opCount, 64'(expOps));

      // Randomized run with a response scoreboard and fairness tracking
      pending = '0;
      for (int i = 0; i < REQS; i++) waitCnt[i] = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         for (int i = 0; i < REQS; i++) begin
            if (!pending[i] && ($urandom_range(1, 0) == 1)) begin
               pending[i] = 1'b1;
               reqA[i]    = 16'($urandom);
               reqB[i]    = 16'($urandom);
            end
         end
         applyStimulus(pending, ($urandom_range(3, 0) != 0));
         if (!$onehot0(reqReady)) checkOutput("rand_onehot", reqReady, 0);
         if ((reqReady & ~pending) != 0) checkOutput("rand_grant_valid", reqReady & ~pending, 0);
         if (rspValid && rspReady) begin
            expOps++;
            if (expQ.size() == 0) begin
               checkOutput("rand_unexpected_rsp", 1, 0);
            end else begin
               e = expQ.pop_front();
               checkOutput("rand_rsp_id", rspId, e.id);
               checkOutput("rand_rsp_data", rspData, e.prod);
            end
         end
         if (reqReady != 0) begin
            g = 0;
            for (int i = 0; i < REQS; i++) if (reqReady[i]) g = i;
            e.id   = IDW'(g);
            e.prod = {16'b0, reqA[g]} * {16'b0, reqB[g]};
            expQ.push_back(e);
            checkOutput("rand_fairness", (waitCnt[g] <= REQS - 1), 1);
            for (int i = 0; i < REQS; i++) if (pending[i] && i != g) waitCnt[i]++;
            waitCnt[g] = 0;
            pending[g] = 1'b0;
         end
         stepClock();
      end
      for (int c = 0; c < 4; c++) begin
         applyStimulus(4'b0000, 1'b1);
         if (rspValid) begin
            expOps++;
            if (expQ.size() == 0) begin
               checkOutput("drain_unexpected_rsp", 1, 0);
            end else begin
               e = expQ.pop_front();
               checkOutput("drain_rsp_id", rspId, e.id);
               checkOutput("drain_rsp_data", rspData, e.prod);
            end
         end
         stepClock();
      end
      checkOutput("rand_queue_empty", 64'(expQ.size()), 0);
      checkOutput("rand_op_count", opCount, 64'(expOps));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_16bits_arbiter.md
# mult_16bits_arbiter

Round-robin scheduler that shares a single combinational `mult_16bits` instance among `REQS` independent requesters. It accepts at most one operand pair per cycle, registers the operands into the multiplier, and captures the product into a response register tagged with the requester ID. Full backpressure is supported on the response side. It sits between the FP mantissa-multiply clients and the one shared integer multiplier, which is instantiated outside this block.

## Interface

Parameters:
- `N`, 16, operand width; product is `2*N`.
- `REQS`, 4, number of requesters (2..8).
- `IDW`, `$clog2(REQS)`, requester ID width.

Ports:
- `clock`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  `REQS`  per-requester operand pair valid.
- `req_a`  in  `[REQS-1:0][N-1:0]`  multiplicand per requester.
- `req_b`  in  `[REQS-1:0][N-1:0]`  multiplier per requester.
- `req_ready`  out  `REQS`  one-hot grant; handshake when `req_valid[i] & req_ready[i]`.
- `mul_a`  out  `N`  registered operand A to the shared multiplier.
- `mul_b`  out  `N`  registered operand B to the shared multiplier.
- `mul_out`  in  `2*N`  combinational product from the shared multiplier.
- `rsp_valid`  out  1  response valid.
- `rsp_id`  out  `IDW`  requester index for the response.
- `rsp_data`  out  `2*N`  product `A*B`, unsigned, full width.
- `rsp_ready`  in  1  consumer accepts the response.
- `op_count`  out  32  completed responses; wraps modulo 2^32.

## Operation

- Two-stage pipeline: S1 holds operands (`s1_valid`, `s1_id`, `mul_a`, `mul_b`); S2 holds the response (`rsp_valid`, `rsp_id`, `rsp_data`).
- Advance rules:
  - `s2_load = s1_valid & (~rsp_valid | rsp_ready)`.
  - `s1_free = ~s1_valid | s2_load`.
- Arbitration is combinational:
  - When `s1_free` and any `req_valid` is high, assert `req_ready` one-hot for the first valid index searching from `last_grant+1` upward, wrapping modulo `REQS`.
  - Otherwise `req_ready = 0`.
  - `req_ready` never depends on `req_valid` of a non-granted requester.
- On a request handshake:
  - S1 loads `req_a[g]` and `req_b[g]`, and `s1_id = g`.
  - `last_grant` updates to `g`.
- `last_grant` is unchanged in cycles without a handshake.
- If S1 advances with no new grant, `s1_valid` clears. `mul_a` and `mul_b` hold their last values; do not zero them.
- On `s2_load`:
  - `rsp_data` takes `mul_out`.
  - `rsp_id` takes `s1_id`.
  - `rsp_valid` is set.
- When `rsp_valid & rsp_ready & ~s2_load`, `rsp_valid` clears.
- While `rsp_valid & ~rsp_ready`, `rsp_id` and `rsp_data` stay stable.
- `op_count` increments on every `rsp_valid & rsp_ready`.
- Reset values: `s1_valid = 0`, `rsp_valid = 0`, `mul_a = 0`, `mul_b = 0`, `rsp_id = 0`, `rsp_data = 0`, `op_count = 0`, `last_grant = REQS-1` (so requester 0 wins first). `req_ready = 0` in every cycle `reset` is high.
- Reset mid-operation discards both in-flight operations. No response is emitted for them.

## Timing

- Request handshake at edge k makes `mul_a` and `mul_b` valid after edge k.
- The product is captured at edge k+1, so `rsp_valid` is high in the cycle after edge k+1. Latency is 2 cycles from handshake to response.
- Throughput is 1 operation per cycle while `rsp_ready` stays high.
- At most 2 operations are in flight.
- With `rsp_ready` low and both stages full, `req_ready = 0`. It reasserts in the same cycle `rsp_ready` rises, because `s2_load` is combinational.
- Simultaneous response handshake and S1 advance: S2 reloads, `rsp_valid` stays high, and there are no bubbles.
- Single requester streaming: granted every cycle; the pointer does not starve it.
- Max fairness wait: `REQS-1` grants to other requesters.

## Test plan

- **Single request:** req 0, A=40119, B=63669, `rsp_ready=1`.
  - Expect `rsp_valid` 2 cycles after the handshake, `rsp_id=0`, `rsp_data=2554336611`, `op_count=1`.
- **All four requesters valid continuously,** with A=i+1 and B=10.
  - Expect grants 0,1,2,3,0,1 on consecutive cycles.
  - Expect responses in the same order with data 10, 20, 30, 40.
- **Backpressure:** stream from req 2, hold `rsp_ready=0` for 3 cycles.
  - Expect `req_ready=0` once 2 operations are in flight.
  - Expect `rsp_data` and `rsp_id` held stable, no loss or duplication, and an in-order drain after release.
- **Extremes:**
  - A=B=65535: expect `rsp_data=0xFFFE0001`.
  - A=0, B=65535: expect 0.
  - A=1, B=65535: expect 65535.
- **Reset with both stages full:**
  - Next cycle: `rsp_valid=0`, `op_count=0`, `req_ready=0`.
  - After reset: the first grant goes to req 0 when reqs 0 and 3 are both valid.
- **Random:** 100k cycles, random `req_valid`, `rsp_ready` and operands; a scoreboard per ID.
  - Expect every product to equal A*B.
  - Expect no requester to wait more than 3 grants.
  - Expect `op_count` to equal the number of responses.
